// File: rtl/neander_pkg.sv
// Shared types and defaults for the Neander memory responder.
// State encodings are fixed so external tools can decode the FSM.
package neander_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int WAIT_CYCLES_DEF = 2;
    localparam int CNT_WIDTH       = 4;

endpackage

// File: rtl/neander_mem_responder_memory.sv
// Single-port word memory: synchronous write, registered read.
// Read-during-write returns the previous contents of the word.
module memory #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr_in] <= data_in;
        end
        data_out <= mem_q[addr_in];
    end

endmodule

// File: rtl/neander_mem_responder.sv
// Wait-state memory responder for the Neander REM/RDM bus.
// One request is accepted in IDLE, stalled in WAIT, completed in RESP.
module neander_mem_responder
    import neander_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input  logic                  clk_geral,
    input  logic                  reset_geral,
    input  logic                  req,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  ack,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  busy
);

    localparam logic [CNT_WIDTH-1:0] CNT_LOAD =
        (WAIT_CYCLES == 0) ? '0 : CNT_WIDTH'(WAIT_CYCLES - 1);

    state_t                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

    logic                    mem_we;
    logic                    cur_we;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_din;
    logic [DATA_WIDTH-1:0]   mem_dout;

    // In IDLE the live inputs feed the memory so a zero-wait access
    // can commit or read on the accepting edge itself.
    assign cur_we   = (state_q == IDLE) ? we    : we_q;
    assign mem_addr = (state_q == IDLE) ? addr  : addr_q;
    assign mem_din  = (state_q == IDLE) ? wdata : wdata_q;
    assign mem_we   = !reset_geral && (state_d == RESP) && cur_we;

    memory #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_memory (
        .clk      (clk_geral),
        .we       (mem_we),
        .addr_in  (mem_addr),
        .data_in  (mem_din),
        .data_out (mem_dout)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    we_d    = we;
                    addr_d  = addr;
                    wdata_d = wdata;
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
                if (!we_q) begin
                    rdata_d = mem_dout;
                end
            end
            default: state_d = IDLE;
        endcase
        if (reset_geral) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_geral) begin
        if (reset_geral) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // The registered read port is already valid during RESP.
    assign rdata = (state_q == RESP && !we_q) ? mem_dout : rdata_q;
    assign ack   = (state_q == RESP);
    assign busy  = (state_q != IDLE);

endmodule
